bitstream_expander: RTL
=======================

// Module: bitstream_expander
// PURPOSE
//  Sits after entropy_encoder; turns its compressed per-cycle output (OUT_FLAG_BITSTREAM + OUT_BIT_1..5,
//  run-length form for flags 5..7) into a plain byte stream on a valid/ready bus, OUT_LANES bytes/beat.
//  Buffers descriptors so downstream stalls never stall the encoder; reports overflow and illegal flags.
// PARAMETERS
//  BITSTREAM_WIDTH  8   byte width of every OUT_BIT_n and of each output lane
//  OUT_LANES        4   bytes per output beat (1..8)
//  DESC_DEPTH       8   descriptor FIFO entries (power of 2, >=2)
//  POS_WIDTH        9   in-descriptor byte counter width (max expanded length 258)
// PORTS
//  top_clk            in   1                    clock, rising edge
//  top_reset          in   1                    asynchronous, active-low reset
//  in_flag_bitstream  in   3                    encoder OUT_FLAG_BITSTREAM
//  in_bit_1..in_bit_5 in   BITSTREAM_WIDTH      encoder OUT_BIT_1..5
//  in_flag_last       in   1                    encoder OUT_FLAG_LAST (frame end)
//  out_data           out  OUT_LANES*BW         lane 0 = bits[BW-1:0] = earliest byte
//  out_count          out  $clog2(OUT_LANES+1)  valid lanes this beat (0 only on end-marker beat)
//  out_valid          out  1                    beat valid
//  out_ready          in   1                    downstream accepts beat
//  out_last           out  1                    final beat of a frame
//  fifo_level         out  $clog2(DESC_DEPTH+1) descriptors held
//  err_overflow       out  1                    sticky: descriptor dropped, FIFO full
//  err_flag           out  1                    sticky: flag==4 received
// BEHAVIOUR
//  Reset: FIFO empty, pos=0, state IDLE; out_valid, out_last, out_count, out_data, fifo_level,
//   err_* all 0. Async assert; every register cleared mid-operation, partial descriptor discarded.
//  Capture: descriptor = {flag,b1..b5,last} pushed when (flag in {1,2,3,5,6,7}) or in_flag_last.
//   flag==0 & last -> end-marker (length 0). flag==4 -> not pushed, err_flag<=1 (last still pushes marker).
//  Push accepted when !full, or full and a pop (descriptor retire) occurs same cycle. Else dropped,
//   err_overflow<=1; never overwrites FIFO contents.
//  Expanded length L: flag 1..3 -> L=flag (b1..b_flag); flag 5 -> 1+b3; 6 -> 2+b3; 7 -> 3+b3.
//   Byte order: b1, then b2 repeated b3 times (b3=0 allowed), then b4 (flag>=6), then b5 (flag==7).
//  FSM: IDLE -> EMIT when FIFO non-empty. EMIT: beat = bytes pos..pos+k-1, k=min(OUT_LANES,L-pos);
//   out_count=k, unused lanes 0. On out_valid&&out_ready: pos+=k; if pos+k==L retire head, pos<=0,
//   stay EMIT if another descriptor is (or becomes) present, else IDLE. Beats never mix descriptors.
//  End-marker: single beat, out_count=0, out_last=1. out_last=1 on the final beat of any descriptor with last=1.
//  Handshake: out_data/out_count/out_last held stable while out_valid && !out_ready; out_valid not
//   dropped until accepted.
//  Latency: descriptor pushed in cycle t -> out_valid at t+1 earliest (FIFO registered, beat comb. from head+pos).
//  Throughput: one beat/cycle with out_ready=1; back-to-back descriptors, no bubble at retire.
//  Arithmetic: L, pos in POS_WIDTH unsigned; b3 zero-extended; no wrap possible (L<=258<512).
// STRUCTURE
//  ee_bitstream_pkg: flag constants (FLAG_NONE=0..FLAG_RUN_B4_B5=7, FLAG_ILLEGAL=4), desc_t struct,
//   function expanded_len(desc_t).
//  One sub-module: ee_desc_fifo (sync FIFO, width $bits(desc_t), depth DESC_DEPTH, full/empty/level).
//  Expander FSM, pos counter, lane mux in this file.
// TESTING
//  1 flag=3 b1..b3=0x11,0x22,0x33, out_ready=1, OUT_LANES=4 -> one beat t+1, count=3, data=0x00332211.
//  2 flag=7 b1=0xA0 b2=0xFF b3=5 b4=0xB4 b5=0xB5 -> 8 bytes A0,FF x5,B4,B5: beats count 4,4.
//  3 flag=5 b3=0 -> single beat count=1 byte b1; flag=0 last=1 -> beat count=0, out_last=1.
//  4 out_ready=0, push 9 descriptors, DESC_DEPTH=8 -> level=8, err_overflow=1, 9th absent from stream;
//    beat held stable throughout stall.
//  5 flag=4 -> no output, err_flag=1 sticky; following flag=1 emitted normally.
//  6 reset low mid flag=7 b3=200 expansion -> outputs 0 immediately; after release, new input streams clean.

Source files
------------

// File: rtl/ee_bitstream_pkg.sv
// Shared definitions for the entropy-encoder bitstream expander: flag codes,
// the captured descriptor layout, and the helpers that expand a descriptor.
package ee_bitstream_pkg;

  localparam int DESC_BW        = 8;
  localparam int DESC_POS_WIDTH = 9;

  localparam logic [2:0] FLAG_NONE      = 3'd0;
  localparam logic [2:0] FLAG_B1        = 3'd1;
  localparam logic [2:0] FLAG_B1_B2     = 3'd2;
  localparam logic [2:0] FLAG_B1_B3     = 3'd3;
  localparam logic [2:0] FLAG_ILLEGAL   = 3'd4;
  localparam logic [2:0] FLAG_RUN       = 3'd5;
  localparam logic [2:0] FLAG_RUN_B4    = 3'd6;
  localparam logic [2:0] FLAG_RUN_B4_B5 = 3'd7;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } exp_state_t;

  typedef struct packed {
    logic [2:0]         flag;
    logic [DESC_BW-1:0] b1;
    logic [DESC_BW-1:0] b2;
    logic [DESC_BW-1:0] b3;
    logic [DESC_BW-1:0] b4;
    logic [DESC_BW-1:0] b5;
    logic               last;
  } desc_t;

  function automatic logic [DESC_POS_WIDTH-1:0] expanded_len(input desc_t d);
    logic [DESC_POS_WIDTH-1:0] len_v;
    len_v = 9'd0;
    case (d.flag)
      FLAG_B1:        len_v = 9'd1;
      FLAG_B1_B2:     len_v = 9'd2;
      FLAG_B1_B3:     len_v = 9'd3;
      FLAG_RUN:       len_v = {1'b0, d.b3} + 9'd1;
      FLAG_RUN_B4:    len_v = {1'b0, d.b3} + 9'd2;
      FLAG_RUN_B4_B5: len_v = {1'b0, d.b3} + 9'd3;
      default:        len_v = 9'd0;
    endcase
    return len_v;
  endfunction

  // Byte idx of the expansion: b1, then b2 repeated b3 times, then b4, b5 for runs.
  function automatic logic [DESC_BW-1:0] byte_at(input desc_t d,
                                                 input logic [DESC_POS_WIDTH-1:0] idx);
    logic [DESC_BW-1:0]        byte_v;
    logic [DESC_POS_WIDTH-1:0] run_end_v;
    run_end_v = {1'b0, d.b3};
    byte_v    = 8'd0;
    if (idx == 9'd0) begin
      byte_v = d.b1;
    end else if (d.flag >= FLAG_RUN) begin
      if (idx <= run_end_v) begin
        byte_v = d.b2;
      end else if (idx == run_end_v + 9'd1) begin
        byte_v = d.b4;
      end else if (idx == run_end_v + 9'd2) begin
        byte_v = d.b5;
      end else begin
        byte_v = 8'd0;
      end
    end else begin
      if (idx == 9'd1) begin
        byte_v = d.b2;
      end else if (idx == 9'd2) begin
        byte_v = d.b3;
      end else begin
        byte_v = 8'd0;
      end
    end
    return byte_v;
  endfunction

endpackage

// File: rtl/ee_desc_fifo.sv
// Synchronous descriptor FIFO; a push while full is taken only when a pop
// frees a slot in the same cycle, so stored entries are never overwritten.
module ee_desc_fifo #(
  parameter int WIDTH = 44,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       srst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic             full_s;
  logic             empty_s;

  assign full_s    = (level_r == LW'(DEPTH));
  assign empty_s   = (level_r == '0);
  assign pop_ok_s  = pop && !empty_s;
  assign push_ok_s = push && (!full_s || pop_ok_s);

  // Storage and pointer/level bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else if (srst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = full_s;
  assign empty = empty_s;
  assign level = level_r;

endmodule

// File: rtl/bitstream_expander.sv
// Expands entropy-encoder descriptors (literal bytes or b1/run/b4/b5 form)
// into a byte stream of OUT_LANES bytes per valid/ready beat.
module bitstream_expander
  import ee_bitstream_pkg::*;
#(
  parameter int BITSTREAM_WIDTH = DESC_BW,
  parameter int OUT_LANES       = 4,
  parameter int DESC_DEPTH      = 8,
  parameter int POS_WIDTH       = DESC_POS_WIDTH
) (
  input  logic                                 top_clk,
  input  logic                                 top_reset,
  input  logic [2:0]                           in_flag_bitstream,
  input  logic [BITSTREAM_WIDTH-1:0]           in_bit_1,
  input  logic [BITSTREAM_WIDTH-1:0]           in_bit_2,
  input  logic [BITSTREAM_WIDTH-1:0]           in_bit_3,
  input  logic [BITSTREAM_WIDTH-1:0]           in_bit_4,
  input  logic [BITSTREAM_WIDTH-1:0]           in_bit_5,
  input  logic                                 in_flag_last,
  output logic [OUT_LANES*BITSTREAM_WIDTH-1:0] out_data,
  output logic [$clog2(OUT_LANES+1)-1:0]       out_count,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_last,
  output logic [$clog2(DESC_DEPTH+1)-1:0]      fifo_level,
  output logic                                 err_overflow,
  output logic                                 err_flag
);

  localparam int CW  = $clog2(OUT_LANES+1);
  localparam int LVW = $clog2(DESC_DEPTH+1);
  localparam int BW  = BITSTREAM_WIDTH;

  desc_t                         cap_desc_s;
  desc_t                         head_s;
  logic                          push_req_s;
  logic                          push_ok_s;
  logic                          illegal_s;
  logic [$bits(desc_t)-1:0]      head_raw_s;
  logic                          full_s;
  logic                          empty_s;
  logic [LVW-1:0]                level_s;
  logic                          valid_s;
  logic                          fire_s;
  logic                          done_s;
  logic                          pop_s;
  logic [POS_WIDTH-1:0]          head_len_s;
  logic [POS_WIDTH-1:0]          remain_s;
  logic [POS_WIDTH-1:0]          k_s;
  logic [OUT_LANES*BW-1:0]       beat_data_s;
  logic [POS_WIDTH-1:0]          pos_r;
  exp_state_t                    state_r;
  exp_state_t                    state_nxt_s;
  logic                          err_overflow_r;
  logic                          err_flag_r;

  // Descriptor capture; an illegal flag carrying last still yields an end marker.
  always_comb begin
    illegal_s       = (in_flag_bitstream == FLAG_ILLEGAL);
    push_req_s      = ((in_flag_bitstream != FLAG_NONE) && !illegal_s) || in_flag_last;
    cap_desc_s.flag = illegal_s ? FLAG_NONE : in_flag_bitstream;
    cap_desc_s.b1   = in_bit_1;
    cap_desc_s.b2   = in_bit_2;
    cap_desc_s.b3   = in_bit_3;
    cap_desc_s.b4   = in_bit_4;
    cap_desc_s.b5   = in_bit_5;
    cap_desc_s.last = in_flag_last;
  end

  ee_desc_fifo #(
    .WIDTH ($bits(desc_t)),
    .DEPTH (DESC_DEPTH)
  ) u_desc_fifo (
    .clk   (top_clk),
    .rst_n (top_reset),
    .srst  (1'b0),
    .push  (push_req_s),
    .pop   (pop_s),
    .wdata (cap_desc_s),
    .rdata (head_raw_s),
    .full  (full_s),
    .empty (empty_s),
    .level (level_s)
  );

  assign head_s     = desc_t'(head_raw_s);
  assign head_len_s = expanded_len(head_s);
  assign remain_s   = head_len_s - pos_r;
  assign k_s        = (remain_s > POS_WIDTH'(OUT_LANES)) ? POS_WIDTH'(OUT_LANES) : remain_s;
  assign done_s     = (remain_s <= POS_WIDTH'(OUT_LANES));
  assign valid_s    = !empty_s;
  assign fire_s     = valid_s && out_ready;
  assign pop_s      = fire_s && done_s;
  assign push_ok_s  = push_req_s && (!full_s || pop_s);

  for (genvar j = 0; j < OUT_LANES; j++) begin : g_lane
    logic [POS_WIDTH-1:0] lane_idx_s;
    assign lane_idx_s = pos_r + POS_WIDTH'(j);
    assign beat_data_s[j*BW +: BW] = (valid_s && (POS_WIDTH'(j) < k_s)) ?
                                     byte_at(head_s, lane_idx_s) : '0;
  end

  // Next-state: keep emitting while a descriptor is held or arrives as the head retires.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) state_nxt_s = ST_EMIT;
        else          state_nxt_s = ST_IDLE;
      end
      ST_EMIT: begin
        if (empty_s)                                              state_nxt_s = ST_IDLE;
        else if (pop_s && (level_s == LVW'(1)) && !push_ok_s)     state_nxt_s = ST_IDLE;
        else                                                      state_nxt_s = ST_EMIT;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and in-descriptor byte position.
  always_ff @(posedge top_clk or negedge top_reset) begin
    if (!top_reset) begin
      state_r <= ST_IDLE;
      pos_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (fire_s && !done_s)      pos_r <= pos_r + k_s;
      else if (fire_s)            pos_r <= '0;
      else if (state_r == ST_IDLE) pos_r <= '0;
      else                        pos_r <= pos_r;
    end
  end

  // Sticky error flags.
  always_ff @(posedge top_clk or negedge top_reset) begin
    if (!top_reset) begin
      err_overflow_r <= 1'b0;
      err_flag_r     <= 1'b0;
    end else begin
      if (push_req_s && !push_ok_s) err_overflow_r <= 1'b1;
      if (illegal_s)                err_flag_r     <= 1'b1;
    end
  end

  assign out_valid    = valid_s;
  assign out_data     = beat_data_s;
  assign out_count    = valid_s ? k_s[CW-1:0] : '0;
  assign out_last     = valid_s && head_s.last && done_s;
  assign fifo_level   = level_s;
  assign err_overflow = err_overflow_r;
  assign err_flag     = err_flag_r;

endmodule
